// File: rtl/io_pkg.sv
// Shared definitions for the I/O register slice: register map and the
// interrupt controller handshake states.
package io_pkg;

    localparam logic [1:0] IRQ_ADDR_MASK = 2'd0;
    localparam logic [1:0] IRQ_ADDR_PEND = 2'd1;
    localparam logic [1:0] IRQ_ADDR_STAT = 2'd2;

    localparam int IRQ_STAT_INSVC_BIT = 7;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SERVICE
    } irq_state_t;

endpackage

// File: rtl/prio_enc.sv
// Fixed-priority encoder: returns the lowest set index of req.
// Purely combinational.
module prio_enc #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         valid
);

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        idx   = '0;
        valid = |req;
        // Scan from the top down so the lowest set index is written last and wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: latches events as pending, masks, arbitrates by fixed
// priority and runs the irq/ack/eoi handshake with the control unit.
module irq_ctrl
    import io_pkg::*;
#(
    parameter int NIRQ = 4,
    parameter int VW   = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NIRQ-1:0] src,
    input  logic            we,
    input  logic [1:0]      addr,
    input  logic [7:0]      wdata,
    output logic [7:0]      rdata,
    output logic            irq,
    output logic [VW-1:0]   vector,
    input  logic            ack,
    input  logic            eoi
);

    irq_state_t      state_q;
    logic            irq_q;
    logic [VW-1:0]   vector_q;
    logic [NIRQ-1:0] pending_q, pending_d;
    logic [NIRQ-1:0] mask_q, mask_d;
    logic [NIRQ-1:0] clr;
    logic [VW-1:0]   win_idx;
    logic            win_valid;
    logic            sel_live;
    logic            in_service;
    logic            unused_wdata;

    assign unused_wdata = ^wdata;
    assign in_service   = (state_q == SERVICE);

    prio_enc #(
        .N(NIRQ),
        .W(VW)
    ) u_prio_enc (
        .req  (pending_q & mask_q),
        .idx  (win_idx),
        .valid(win_valid)
    );

    always_comb begin
        mask_d = mask_q;
        clr    = '0;
        if (we && addr == IRQ_ADDR_MASK) begin
            mask_d = wdata[NIRQ-1:0];
        end
        if (we && addr == IRQ_ADDR_PEND) begin
            clr = wdata[NIRQ-1:0];
        end
        if (state_q == REQ && ack) begin
            clr[vector_q] = 1'b1;
        end
        // A new event on the same edge as any clear keeps the bit set.
        pending_d = (pending_q & ~clr) | src;
    end

    // Looks at next-cycle values so a request withdrawn by software drops irq on the write edge.
    assign sel_live = pending_d[vector_q] & mask_d[vector_q];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= '0;
            mask_q    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            pending_q <= pending_d;
            mask_q    <= mask_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            irq_q    <= 1'b0;
            vector_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_valid) begin
                        state_q  <= REQ;
                        vector_q <= win_idx;
                        irq_q    <= 1'b1;
                    end
                end
                REQ: begin
                    if (ack) begin
                        state_q <= SERVICE;
                        irq_q   <= 1'b0;
                    end else if (!sel_live) begin
                        state_q <= IDLE;
                        irq_q   <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (eoi) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    irq_q   <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
            IRQ_ADDR_MASK: rdata[NIRQ-1:0] = mask_q;
            IRQ_ADDR_PEND: rdata[NIRQ-1:0] = pending_q;
            IRQ_ADDR_STAT: begin
                rdata[IRQ_STAT_INSVC_BIT] = in_service;
                rdata[VW-1:0]             = vector_q;
            end
            default: ;
        endcase
    end

    assign irq    = irq_q;
    assign vector = vector_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: handshake, priority, masking, withdrawal,
// collisions, async reset and a periodic event source.
module tb_irq_ctrl;

    localparam int NIRQ = 4;
    localparam int VW   = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic [NIRQ-1:0] src;
    logic            we;
    logic [1:0]      addr;
    logic [7:0]      wdata;
    logic [7:0]      rdata;
    logic            irq;
    logic [VW-1:0]   vector;
    logic            ack;
    logic            eoi;

    int n_tests = 0;
    int n_fail  = 0;

    irq_ctrl #(
        .NIRQ(NIRQ),
        .VW  (VW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .src   (src),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq),
        .vector(vector),
        .ack   (ack),
        .eoi   (eoi)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    // Advance one clock; return 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        we    = 1'b1;
        addr  = a;
        wdata = d;
        tick();
        we    = 1'b0;
        wdata = 8'h00;
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] a, input logic [7:0] exp);
        addr = a;
        #1;
        check(tag, rdata, exp);
    endtask

    task automatic chk_irq(input string tag, input logic exp_irq, input logic [VW-1:0] exp_vec);
        check({tag, "_irq"}, {7'd0, irq}, {7'd0, exp_irq});
        if (exp_irq) begin
            check({tag, "_vec"}, {5'd0, vector}, {5'd0, exp_vec});
        end
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic do_eoi();
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
    endtask

    task automatic pulse(input logic [NIRQ-1:0] s);
        src = s;
        tick();
        src = '0;
    endtask

    initial begin
        int acks;
        int bad_vec;
        int dup;

        reset = 1'b1;
        src   = '0;
        we    = 1'b0;
        addr  = 2'd0;
        wdata = 8'h00;
        ack   = 1'b0;
        eoi   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        chk_irq("reset", 1'b0, '0);
        check("reset_vec", {5'd0, vector}, 8'h00);
        chk_reg("reset_mask", 2'd0, 8'h00);
        chk_reg("reset_pend", 2'd1, 8'h00);
        chk_reg("reset_stat", 2'd2, 8'h00);
        chk_reg("rsvd_read", 2'd3, 8'h00);

        // Stray strobes in IDLE, and a write to the reserved address
        ack = 1'b1;
        eoi = 1'b1;
        tick();
        ack = 1'b0;
        eoi = 1'b0;
        wr(2'd3, 8'hFF);
        chk_irq("stray", 1'b0, '0);
        chk_reg("stray_stat", 2'd2, 8'h00);
        chk_reg("stray_mask", 2'd0, 8'h00);

        // Basic request
        wr(2'd0, 8'h01);
        chk_reg("basic_mask", 2'd0, 8'h01);
        pulse(4'b0001);
        chk_irq("basic_n", 1'b0, '0);
        chk_reg("basic_pend", 2'd1, 8'h01);
        tick();
        chk_irq("basic_n1", 1'b1, 3'd0);
        do_ack();
        chk_irq("basic_ack", 1'b0, '0);
        chk_reg("basic_ack_pend", 2'd1, 8'h00);
        chk_reg("basic_ack_stat", 2'd2, 8'h80);
        do_eoi();
        chk_reg("basic_eoi_stat", 2'd2, 8'h00);

        // Priority and freezing
        wr(2'd0, 8'h0F);
        pulse(4'b1100);
        tick();
        chk_irq("prio_first", 1'b1, 3'd2);
        pulse(4'b0010);
        chk_irq("prio_frozen", 1'b1, 3'd2);
        chk_reg("prio_pend", 2'd1, 8'h0E);
        do_ack();
        chk_irq("prio_ack", 1'b0, '0);
        chk_reg("prio_ack_pend", 2'd1, 8'h0A);
        chk_reg("prio_ack_stat", 2'd2, 8'h82);
        do_eoi();
        chk_irq("prio_gap", 1'b0, '0);
        tick();
        chk_irq("prio_second", 1'b1, 3'd1);
        do_ack();
        chk_reg("prio_second_pend", 2'd1, 8'h08);
        do_eoi();
        tick();
        chk_irq("prio_third", 1'b1, 3'd3);
        do_ack();
        do_eoi();
        chk_reg("prio_done_pend", 2'd1, 8'h00);

        // Masking
        wr(2'd0, 8'h00);
        pulse(4'b0100);
        tick();
        chk_reg("mask_pend", 2'd1, 8'h04);
        chk_irq("mask_blocked", 1'b0, '0);
        wr(2'd0, 8'h04);
        chk_irq("mask_w", 1'b0, '0);
        tick();
        chk_irq("mask_w1", 1'b1, 3'd2);
        do_ack();
        do_eoi();

        // Withdrawal in REQ
        wr(2'd0, 8'h02);
        pulse(4'b0010);
        tick();
        chk_irq("wd_req", 1'b1, 3'd1);
        wr(2'd0, 8'h00);
        chk_irq("wd_drop", 1'b0, '0);
        chk_reg("wd_pend", 2'd1, 8'h02);
        check("wd_insvc", rdata & 8'h00, 8'h00);
        chk_reg("wd_stat_insvc", 2'd2, {1'b0, 4'd0, 3'd1});
        tick();
        chk_irq("wd_idle", 1'b0, '0);
        wr(2'd0, 8'h02);
        tick();
        chk_irq("wd_rearm", 1'b1, 3'd1);
        do_ack();
        do_eoi();
        chk_reg("wd_done_pend", 2'd1, 8'h00);

        // Collision: event on the ack edge for the same source
        wr(2'd0, 8'h01);
        pulse(4'b0001);
        tick();
        chk_irq("col_req", 1'b1, 3'd0);
        src = 4'b0001;
        do_ack();
        src = '0;
        chk_irq("col_ack", 1'b0, '0);
        chk_reg("col_ack_pend", 2'd1, 8'h01);
        chk_reg("col_ack_stat", 2'd2, 8'h80);
        do_eoi();
        chk_irq("col_gap", 1'b0, '0);
        tick();
        chk_irq("col_again", 1'b1, 3'd0);
        do_ack();
        do_eoi();

        // Collision: software clear on the same edge as an event
        src = 4'b0001;
        wr(2'd1, 8'h01);
        src = '0;
        chk_reg("colw_pend", 2'd1, 8'h01);
        tick();
        chk_irq("colw_req", 1'b1, 3'd0);
        do_ack();
        do_eoi();

        // Async reset mid-SERVICE
        pulse(4'b0001);
        tick();
        do_ack();
        pulse(4'b0001);
        chk_reg("ar_pre_stat", 2'd2, 8'h80);
        chk_reg("ar_pre_pend", 2'd1, 8'h01);
        #1;
        reset = 1'b1;
        #1;
        chk_irq("ar", 1'b0, '0);
        chk_reg("ar_pend", 2'd1, 8'h00);
        chk_reg("ar_mask", 2'd0, 8'h00);
        chk_reg("ar_stat", 2'd2, 8'h00);
        tick();
        reset = 1'b0;

        // Periodic source with limit 3: one pulse every 4 cycles
        wr(2'd0, 8'h01);
        addr    = 2'd2;
        acks    = 0;
        bad_vec = 0;
        dup     = 0;
        for (int c = 0; c < 48; c++) begin
            src = {3'b000, (c % 4 == 3) && (c < 40)};
            ack = irq;
            eoi = rdata[7];
            if (irq) begin
                acks++;
                if (vector !== 3'd0) bad_vec++;
                if (rdata[7]) dup++;
            end
            tick();
        end
        src = '0;
        ack = 1'b0;
        eoi = 1'b0;
        check("timer_acks", 8'(acks), 8'd10);
        check("timer_vec", 8'(bad_vec), 8'd0);
        check("timer_overlap", 8'(dup), 8'd0);
        chk_reg("timer_pend", 2'd1, 8'h00);
        chk_reg("timer_stat", 2'd2, 8'h00);
        chk_irq("timer_end", 1'b0, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
